seq_bit_serializer: RTL and testbench
=====================================

SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning serialized word width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port din_valid  input  1  din holds a word for transfer.
REQ-006 SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port x  output  1  serial bit stream to the downstream Moore sequence detector.
REQ-008 SHALL have port x_valid  output  1  x carries a data bit (0 means idle fill).
REQ-009 SHALL have port busy  output  1  a word is being shifted or is held in the buffer.
REQ-010 SHALL have port word_done  output  1  one-cycle pulse with the last bit of each word.

Function
REQ-011 SHALL transfer a word on a rising edge where din_valid and din_ready are both 1; din_valid without din_ready SHALL have no effect.
REQ-012 SHALL use FSM states IDLE and SHIFT: IDLE->SHIFT on transfer; SHIFT->SHIFT while bits remain or the next word loads; SHIFT->IDLE after the last bit with no next word.
REQ-013 SHALL shift MSB first: for a transfer at edge k, x = din[WIDTH-1-i] and x_valid = 1 in the cycle after edge k+i, i = 0..WIDTH-1.
REQ-014 SHALL drive all outputs from registers except din_ready; latency from transfer to first bit is one cycle.
REQ-015 SHALL drive x = 0 and x_valid = 0 in IDLE, so the detector sees a zero stream between words.
REQ-016 SHALL assert word_done for exactly one cycle, coincident with the bit i = WIDTH-1.
REQ-017 SHALL hold a bit counter of width ceil(log2(WIDTH)) that reloads to WIDTH-1 on each word load; wrap past 0 is forbidden.
REQ-018 SHALL assert busy in SHIFT, or while a buffered word is pending.
REQ-019 SHALL leave din_ready independent of din_valid (no combinational loop).

Reset
REQ-020 SHALL, while rst = 0, force state IDLE, x = 0, x_valid = 0, word_done = 0, busy = 0, din_ready = 0, with counter, shift register and buffer cleared.
REQ-021 SHALL, on reset asserted mid-word, discard the partial word and any buffered word; no word_done SHALL follow.
REQ-022 SHALL take din_ready = 1 from the first rising edge after rst goes high.

Configuration
REQ-023 SHALL honour macro SEQ_SER_SKID_BUF_EN.
REQ-024 Without SEQ_SER_SKID_BUF_EN: din_ready = 1 only in IDLE; consecutive words SHALL be separated by at least one idle cycle (x_valid = 0).
REQ-025 With SEQ_SER_SKID_BUF_EN: a one-entry buffer SHALL be added, with din_ready = 1 while the buffer is empty, including during SHIFT.
REQ-026 With SEQ_SER_SKID_BUF_EN: a buffered word SHALL load on the edge after the last bit, giving back-to-back bits with x_valid continuously 1.
REQ-027 With SEQ_SER_SKID_BUF_EN: a transfer in IDLE SHALL bypass the buffer directly into the shift register.
REQ-028 With SEQ_SER_SKID_BUF_EN: a transfer in the last-bit cycle with the buffer empty SHALL load directly into the shift register, with no buffer stall.

Structure
REQ-029 SHALL take from shared package seq_pkg: the state enum (IDLE, SHIFT), the WIDTH default constant, and the counter-width function.
REQ-030 SHALL place the buffer in sub-module seq_skid_buf, instantiated only under SEQ_SER_SKID_BUF_EN.

Verification
REQ-031 Reset check: rst = 0 for 3 cycles, then release -> during reset x = 0, x_valid = 0, din_ready = 0, busy = 0; din_ready = 1 one edge after release.
REQ-032 Single word: din = 8'h96 accepted at edge k -> x = 1,0,0,1,0,1,1,0 in the cycles after edges k..k+7; word_done only with the final 0; IDLE afterwards.
REQ-033 Back-to-back, macro off: 8'hA5 then 8'h3C held valid -> one x_valid = 0 gap cycle between words; din_ready = 0 throughout SHIFT.
REQ-034 Back-to-back, macro on: 8'hA5 then 8'h3C -> 16 contiguous x_valid = 1 cycles; second word accepted during SHIFT; two word_done pulses 8 cycles apart.
REQ-035 Reset mid-word: rst = 0 after bit 3 of 8'hFF -> x = 0 immediately; no word_done; next word 8'h01 serializes correctly.
REQ-036 Detector chain: the serializer drives a Moore non-overlapping detector; 8'h96 -> detector matches identical to a bit-level reference stream with one-cycle offset.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared types and helpers for the bit-serializer slice.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int c_WIDTH_DEFAULT = 8;

    // ceil(log2(w)), never less than 1; the loop is bounded for w <= 32
    function automatic int cnt_width(input int w);
        int r;
        r = 1;
        for (int i = 1; i < 6; i++) begin
            if ((1 << i) < w) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : seq_skid_buf
// Brief    : One-entry holding buffer for a word arriving mid-shift.
// Revision : 1.0 - initial release
// ============================================================================
module seq_skid_buf
    import seq_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic [WIDTH-1:0] rd_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // A write is only offered while empty, so write and read never collide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            if (wr_en) begin
                r_full <= 1'b1;
                r_data <= wr_data;
            end else if (rd_en) begin
                r_full <= 1'b0;
            end
        end
    end

    assign full    = r_full;
    assign rd_data = r_data;

endmodule
`default_nettype wire

// File: rtl/seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : seq_bit_serializer
// Brief    : MSB-first parallel-to-serial converter feeding a sequence
//            detector. Macro SEQ_SER_SKID_BUF_EN adds a one-word skid buffer
//            for gap-free back-to-back words.
// Revision : 1.0 - initial release
// ============================================================================
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int              c_CW      = cnt_width(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

    state_t            r_state;
    logic [WIDTH-1:0]  r_shreg;
    logic [c_CW-1:0]   r_cnt;
    logic              r_x;
    logic              r_x_valid;
    logic              r_word_done;
    logic              r_busy;
    logic              r_up;

    logic              w_xfer;
    logic              w_last;
    logic              w_load;
    logic              w_next_shift;
    logic              w_next_buf_full;
    logic [WIDTH-1:0]  w_load_data;

    assign w_last = (r_state == SHIFT) && (r_cnt == '0);

`ifdef SEQ_SER_SKID_BUF_EN
    logic              w_buf_full;
    logic              w_buf_wr;
    logic              w_buf_rd;
    logic [WIDTH-1:0]  w_buf_data;

    assign din_ready       = r_up && !w_buf_full;
    assign w_xfer          = din_valid && din_ready;
    // Only a word arriving with bits still pending has to wait in the buffer
    assign w_buf_wr        = w_xfer && (r_state == SHIFT) && !w_last;
    assign w_buf_rd        = w_last && w_buf_full;
    assign w_load          = (w_xfer && !w_buf_wr) || w_buf_rd;
    assign w_load_data     = w_buf_rd ? w_buf_data : din;
    assign w_next_buf_full = (w_buf_full && !w_buf_rd) || w_buf_wr;

    seq_skid_buf #(
        .WIDTH   (WIDTH)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_buf_wr),
        .wr_data (din),
        .rd_en   (w_buf_rd),
        .full    (w_buf_full),
        .rd_data (w_buf_data)
    );
`else
    assign din_ready       = r_up && (r_state == IDLE);
    assign w_xfer          = din_valid && din_ready;
    assign w_load          = w_xfer;
    assign w_load_data     = din;
    assign w_next_buf_full = 1'b0;
`endif

    assign w_next_shift = w_load || ((r_state == SHIFT) && (r_cnt != '0));

    // r_cnt counts bits still to follow the one currently on x
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_x         <= 1'b0;
            r_x_valid   <= 1'b0;
            r_word_done <= 1'b0;
            r_busy      <= 1'b0;
            r_up        <= 1'b0;
        end else begin
            r_up   <= 1'b1;
            r_busy <= w_next_shift || w_next_buf_full;
            if (w_load) begin
                r_state     <= SHIFT;
                r_x         <= w_load_data[WIDTH-1];
                r_x_valid   <= 1'b1;
                r_shreg     <= {w_load_data[WIDTH-2:0], 1'b0};
                r_cnt       <= c_CNT_MAX;
                r_word_done <= 1'b0;
            end else if ((r_state == SHIFT) && (r_cnt != '0)) begin
                r_x         <= r_shreg[WIDTH-1];
                r_shreg     <= {r_shreg[WIDTH-2:0], 1'b0};
                r_cnt       <= r_cnt - c_CNT_ONE;
                r_word_done <= (r_cnt == c_CNT_ONE);
            end else begin
                r_state     <= IDLE;
                r_x         <= 1'b0;
                r_x_valid   <= 1'b0;
                r_word_done <= 1'b0;
            end
        end
    end

    assign x         = r_x;
    assign x_valid   = r_x_valid;
    assign busy      = r_busy;
    assign word_done = r_word_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_bit_serializer
// Brief    : Scoreboard bench for seq_bit_serializer with a "101" Moore
//            detector on the serial stream; follows SEQ_SER_SKID_BUF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       word_done;

    seq_bit_serializer #(
        .WIDTH     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .busy      (busy),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic done;
        logic first;
    } exp_t;

    exp_t exp_q[$];
    bit   vlog[$];
    int   runs[$];
    int   gaps[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   det_cyc = 0;
    int   det_cnt = 0;
    int   det_base = 0;
    int   ref_cnt;
    int   ref_idx;
    int   cur;
    int   zc;
    bit   started;
    bit   det_seen = 1'b0;
    bit   mon_en = 1'b0;
    bit   log_en = 1'b0;
    bit   in_shift;
    logic [1:0] det_st;
    logic       det_out;

    // Moore non-overlapping "101" detector driven by the serial stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_st <= 2'd0;
        end else begin
            case (det_st)
                2'd0:    det_st <= (x & x_valid) ? 2'd1 : 2'd0;
                2'd1:    det_st <= (x & x_valid) ? 2'd1 : 2'd2;
                2'd2:    det_st <= (x & x_valid) ? 2'd3 : 2'd0;
                default: det_st <= (x & x_valid) ? 2'd1 : 2'd0;
            endcase
        end
    end
    assign det_out = (det_st == 2'd3);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_det(input logic [7:0] w, output int cnt, output int idx);
        logic [11:0] s;
        int i;
        s   = {w, 4'b0000};
        cnt = 0;
        idx = -1;
        i   = 0;
        while (i <= 9) begin
            if (s[11-i] && !s[10-i] && s[9-i]) begin
                if (idx < 0) idx = i + 2;
                cnt++;
                i += 3;
            end else begin
                i++;
            end
        end
    endfunction

    // Output monitor: pops the scoreboard for every valid bit
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mon_en && rst) begin
            if (log_en) vlog.push_back(x_valid);
            if (x_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("x_valid_unexpected", x_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("x_bit", x, e.b);
                    check("word_done", word_done, e.done);
                    check("busy_shift", busy, 1'b1);
                    if (e.first) start_cyc = cyc;
`ifndef SEQ_SER_SKID_BUF_EN
                    check("din_ready_shift", din_ready, 1'b0);
`endif
                end
            end else begin
                check("x_idle", x, 1'b0);
                check("word_done_idle", word_done, 1'b0);
            end
            if (det_out === 1'b1) begin
                if (!det_seen) det_cyc = cyc;
                det_seen = 1'b1;
                det_cnt++;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic send(input logic [7:0] w, output bit shifting);
        int n;
        n         = 0;
        din       = w;
        din_valid = 1'b1;
        while (din_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", n >= 50, 1'b0);
        shifting = x_valid;
        for (int i = 0; i < 8; i++) exp_q.push_back('{w[7-i], i == 7, i == 0});
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0 && x_valid === 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n >= 100, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_din_ready", din_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_x", x, 1'b0);
            check("rst_x_valid", x_valid, 1'b0);
            check("rst_din_ready", din_ready, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_word_done", word_done, 1'b0);
        end
        rst = 1'b1;
        #1;
        check("rel_din_ready_pre_edge", din_ready, 1'b0);
        @(negedge clk);
        check("rel_din_ready", din_ready, 1'b1);
        check("rel_busy", busy, 1'b0);
        mon_en = 1'b1;

        // Single word 0x96 through the detector
        @(negedge clk);
        det_seen = 1'b0;
        det_base = det_cnt;
        send(8'h96, in_shift);
        din_valid = 1'b0;
        wait_idle();
        ref_det(8'h96, ref_cnt, ref_idx);
        check("det_count", det_cnt - det_base, ref_cnt);
        check("det_offset", det_cyc - start_cyc, ref_idx + 1);

        // Back-to-back 0xA5 then 0x3C with valid held
        @(negedge clk);
        vlog.delete();
        log_en = 1'b1;
        send(8'hA5, in_shift);
        send(8'h3C, in_shift);
        din_valid = 1'b0;
        wait_idle();
        log_en  = 1'b0;
        cur     = 0;
        zc      = 0;
        started = 1'b0;
        runs.delete();
        gaps.delete();
        foreach (vlog[i]) begin
            if (vlog[i]) begin
                if (started && cur == 0) gaps.push_back(zc);
                cur++;
                started = 1'b1;
                zc = 0;
            end else begin
                if (cur > 0) runs.push_back(cur);
                cur = 0;
                zc++;
            end
        end
        if (cur > 0) runs.push_back(cur);
`ifdef SEQ_SER_SKID_BUF_EN
        check("b2b_runs", runs.size(), 1);
        if (runs.size() >= 1) check("b2b_run_len", runs[0], 16);
        check("b2b_accept_in_shift", in_shift, 1'b1);
`else
        check("b2b_runs", runs.size(), 2);
        if (runs.size() >= 2) begin
            check("b2b_run0", runs[0], 8);
            check("b2b_run1", runs[1], 8);
        end
        if (gaps.size() >= 1) check("b2b_gap", gaps[0], 1);
        check("b2b_accept_in_shift", in_shift, 1'b0);
`endif

        // Reset after bit 3 of 0xFF, then 0x01
        @(negedge clk);
        send(8'hFF, in_shift);
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_x", x, 1'b0);
        check("mid_rst_x_valid", x_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_word_done", word_done, 1'b0);
        check("mid_rst_din_ready", din_ready, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_word_done", word_done, 1'b0);
        send(8'h01, in_shift);
        din_valid = 1'b0;
        wait_idle();

        // A short burst of random words
        for (int k = 0; k < 4; k++) send(8'($urandom_range(0, 255)), in_shift);
        din_valid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
